icache_refill_responder: RTL and testbench



---
 rtl/icache_pkg.sv | 7 +
 rtl/refill_mem_array.sv | 23 ++
 rtl/icache_refill_responder.sv | 93 +++++++++
 tb/tb_icache_refill_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: line geometry and refill FSM states shared by the icache fill logic and its responder
package icache_pkg;
  localparam int LINE_BEATS = 4;
  localparam int DATA_W = 32;
  localparam int LINE_OFF_W = $clog2(LINE_BEATS * DATA_W / 8);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} refill_state_t;
endpackage

// File: rtl/refill_mem_array.sv
// refill_mem_array: word array with backdoor write port and a registered, zero-on-error read
module refill_mem_array #(
  parameter int DATA_W = 32,
  parameter int MEM_WORDS = 32,
  parameter int IW = $clog2(MEM_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [IW-1:0]     load_idx,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rd_en,
  input  logic              rd_ok,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [MEM_WORDS];
  always_ff @(posedge clock)
    if (load_en) mem[load_idx] <= load_data;
  always_ff @(posedge clock)
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= rd_ok ? mem[rd_idx] : '0;
endmodule

// File: rtl/icache_refill_responder.sv
// icache_refill_responder: serves one line refill at a time after a fixed first-beat latency
module icache_refill_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = icache_pkg::DATA_W,
  parameter int MEM_WORDS = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = 'h8000_0000,
  parameter int LINE_BEATS = icache_pkg::LINE_BEATS,
  parameter int FIRST_LAT = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rlast,
  output logic                         rerr,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_idx,
  input  logic [DATA_W-1:0]            load_data
);
  import icache_pkg::*;
  localparam int IW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(LINE_BEATS);
  localparam int OFF_W = $clog2(LINE_BEATS * DATA_W / 8);
  localparam int WB = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 ** OFF_W - 1);
  refill_state_t state;
  logic [ADDR_W-1:0] base, src, widx;
  logic [BW-1:0] beat, nbeat;
  logic [3:0] lat;
  logic hs, fire, load, in_range;
  assign req_ready = state == IDLE && !reset;
  assign rvalid = state == BURST;
  assign hs = req_valid && req_ready;
  assign fire = rvalid && rready;
  // the read is issued one cycle ahead so rdata is registered when the beat is presented
  always_comb begin
    nbeat = fire ? beat + 1'b1 : '0;
    src = state == IDLE ? req_addr & LINE_MASK : base;
    widx = ((src - MEM_BASE) >> WB) + ADDR_W'(nbeat);
    in_range = widx < ADDR_W'(MEM_WORDS);
    load = (fire && !rlast) || (hs && FIRST_LAT == 0) || (state == WAIT && lat == 4'(FIRST_LAT - 1));
  end
  refill_mem_array #(.DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_mem (
    .clock(clock),
    .reset(reset),
    .load_en(load_en),
    .load_idx(load_idx),
    .load_data(load_data),
    .rd_en(load),
    .rd_ok(in_range),
    .rd_idx(widx[IW-1:0]),
    .rd_data(rdata)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      base <= '0;
      beat <= '0;
      lat <= '0;
      rlast <= 1'b0;
      rerr <= 1'b0;
    end else begin
      if (load) begin
        rlast <= nbeat == BW'(LINE_BEATS - 1);
        rerr <= !in_range;
      end
      case (state)
        IDLE: if (hs) begin
          base <= src;
          beat <= '0;
          lat <= '0;
          state <= FIRST_LAT == 0 ? BURST : WAIT;
        end
        WAIT: begin
          lat <= lat + 1'b1;
          if (lat == 4'(FIRST_LAT - 1)) state <= BURST;
        end
        BURST: if (fire) begin
          beat <= beat + 1'b1;
          if (rlast) begin
            state <= IDLE;
            rlast <= 1'b0;
            rerr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_icache_refill_responder.sv
// tb_icache_refill_responder: randomized scoreboard bench against a line-level reference model
module tb_icache_refill_responder;
  localparam int FL = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
  typedef struct {
    logic [31:0] data;
    logic last;
    logic err;
    int word;
    int due;
  } beat_t;
  logic clock = 0, reset = 1;
  logic req_valid = 0, rready = 1, load_en = 0;
  logic [31:0] req_addr = 0, load_data = 0;
  logic [4:0] load_idx = 0;
  logic req_ready, rvalid, rlast, rerr;
  logic [31:0] rdata;
  logic req_valid0 = 0, rready0 = 1;
  logic [31:0] req_addr0 = 0;
  logic req_ready0, rvalid0, rlast0, rerr0;
  logic [31:0] rdata0;
  logic [31:0] mdl [32];
  beat_t q[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, rv_cnt = 0, last_span = 0;
  bit head_seen = 0, expect_idle = 0, rnd_rr = 0;

  icache_refill_responder #(.FIRST_LAT(FL)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rerr(rerr),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );
  icache_refill_responder #(.FIRST_LAT(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .rvalid(rvalid0), .rready(rready0), .rdata(rdata0), .rlast(rlast0), .rerr(rerr0),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end
  initial forever begin
    @(posedge clock);
    #1;
    if (rnd_rr) rready = $urandom_range(0, 3) != 0;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want completion", cyc);
    $fatal(1);
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // a line is served whole from its aligned base; lines outside the array return zeros with error
  function automatic void push_burst(logic [31:0] a, int hc);
    logic [31:0] line;
    bit ok;
    line = a & ~32'hF;
    ok = line >= BASE && line < BASE + 32'd128;
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.word = -1;
      e.data = 0;
      if (ok) begin
        e.word = int'((line - BASE) / 4) + b;
        e.data = mdl[e.word];
      end
      e.last = b == 3;
      e.err = !ok;
      e.due = b == 0 ? hc + FL + 1 : -1;
      q.push_back(e);
    end
  endfunction

  // a load never alters the beat already on the bus, only beats still to come
  task automatic do_load(int idx, logic [31:0] d);
    load_en = 1;
    load_idx = 5'(idx);
    load_data = d;
    mdl[idx] = d;
    for (int i = rvalid ? 1 : 0; i < q.size(); i++)
      if (q[i].word == idx) q[i].data = d;
    @(posedge clock);
    #1 load_en = 0;
  endtask

  task automatic send(logic [31:0] a);
    req_valid = 1;
    req_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (req_ready) begin
        push_burst(a, cyc);
        @(posedge clock);
        #1 req_valid = 0;
        return;
      end
    end
    chk("req_accept_timeout", 0, 1);
    req_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clock);
    chk("drain_queue_empty", q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial forever begin
    @(negedge clock);
    if (expect_idle) begin
      chk("req_ready_after_last", req_ready, 1);
      chk("rvalid_after_last", rvalid, 0);
      expect_idle = 0;
    end
    if (rvalid) begin
      rv_cnt++;
      if (q.size() == 0) chk("unexpected_beat", rvalid, 0);
      else begin
        if (!head_seen && q[0].due >= 0) chk("first_beat_cycle", cyc, q[0].due);
        head_seen = 1;
        chk("rdata", rdata, q[0].data);
        chk("rlast", rlast, q[0].last);
        chk("rerr", rerr, q[0].err);
        if (rready) begin
          if (q[0].last) begin
            expect_idle = 1;
            last_span = rv_cnt;
            rv_cnt = 0;
          end
          void'(q.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  initial begin
    @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) do_load(i, $urandom);
    do_load(4, 32'h11);
    do_load(5, 32'h22);
    do_load(6, 32'h33);
    do_load(7, 32'h44);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_rvalid0", rvalid0, 0);
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("req_ready_after_reset", req_ready, 1);
    @(posedge clock);
    #1;
    send(32'h8000_0010);
    drain();
    chk("plain_span", last_span, 4);
    send(32'h8000_0010);
    repeat (FL + 2) @(posedge clock);
    #1 rready = 0;
    repeat (3) @(posedge clock);
    #1 rready = 1;
    drain();
    chk("stall_span", last_span, 7);
    send(32'h8000_001C);
    drain();
    send(32'h0000_0000);
    drain();
    send(32'h8000_0080);
    drain();
    send(32'h8000_0010);
    repeat (FL + 2) @(posedge clock);
    #1 rready = 0;
    reset = 1;
    @(posedge clock);
    #1;
    q.delete();
    head_seen = 0;
    rv_cnt = 0;
    expect_idle = 0;
    @(negedge clock);
    chk("midburst_rst_rvalid", rvalid, 0);
    chk("midburst_rst_req_ready", req_ready, 0);
    @(posedge clock);
    #1 reset = 0;
    rready = 1;
    @(negedge clock);
    chk("req_ready_after_midburst_rst", req_ready, 1);
    @(posedge clock);
    #1;
    send(32'h8000_0010);
    drain();
    send(32'h8000_0010);
    repeat (FL + 1) @(posedge clock);
    #1 rready = 0;
    do_load(6, 32'hAA);
    @(posedge clock);
    #1 rready = 1;
    drain();
    req_valid0 = 1;
    req_addr0 = 32'h8000_0014;
    @(negedge clock);
    chk("lat0_req_ready", req_ready0, 1);
    chk("lat0_rvalid_at_hs", rvalid0, 0);
    @(posedge clock);
    #1 req_valid0 = 0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      chk("lat0_rvalid", rvalid0, 1);
      chk("lat0_rdata", rdata0, mdl[4 + b]);
      chk("lat0_rlast", rlast0, b == 3);
      chk("lat0_rerr", rerr0, 0);
    end
    @(negedge clock);
    chk("lat0_idle_rvalid", rvalid0, 0);
    chk("lat0_idle_req_ready", req_ready0, 1);
    @(posedge clock);
    #1 rnd_rr = 1;
    for (int n = 0; n < 48; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0, 1: a = BASE + 32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 15));
        2: a = 32'($urandom_range(0, 32'h7FFF_FFFF));
        3: a = BASE + 32'd128 + 32'($urandom_range(0, 4095));
        default: a = $urandom_range(0, 1) != 0 ? BASE + 32'd112 : BASE - 32'd16;
      endcase
      send(a);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
      end
      if (n % 8 == 7) begin
        drain();
        repeat (3) do_load($urandom_range(0, 31), $urandom);
      end
    end
    rnd_rr = 0;
    @(posedge clock);
    #2 rready = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
